// File: rtl/sreg_bidir.sv
// Bidirectional N-stage shift register with parallel load, registered serial outputs, shift counter and done pulse.
// Single-cycle update, no backpressure (every shift cycle is taken); mode 11 rotates right only with SREG_BIDIR_ROTATE_EN.
module sreg_bidir #(
  parameter int N     = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pl,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         si_r,
  input  logic [WIDTH-1:0]         si_l,
  input  logic [N*WIDTH-1:0]       din,
  output logic [N*WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]         so_r,
  output logic [WIDTH-1:0]         so_l,
  output logic [$clog2(N+1)-1:0]   cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(N+1);
  localparam int DW = N * WIDTH;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_stage, w_stage_nxt;
  logic [WIDTH-1:0]  r_so_r, w_so_r_nxt;
  logic [WIDTH-1:0]  r_so_l, w_so_l_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_done, w_done_nxt;

  logic w_go, w_shr, w_shl, w_rot, w_shift, w_last;

  assign w_go  = en & ~pl;
  assign w_shr = w_go & (mode == 2'b01);
  assign w_shl = w_go & (mode == 2'b10);
`ifdef SREG_BIDIR_ROTATE_EN
  assign w_rot = w_go & (mode == 2'b11);
`else
  assign w_rot = 1'b0;
`endif
  assign w_shift = w_shr | w_shl | w_rot;
  assign w_last  = (r_state == S_ACTIVE) && (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_so_r_nxt  = r_so_r;
    w_so_l_nxt  = r_so_l;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (pl) begin
      // Load wins over any shift in the same cycle, including the final one.
      w_stage_nxt = din;
      w_cnt_nxt   = '0;
      w_state_nxt = S_ACTIVE;
    end else if (w_shift) begin
      if (w_shl) begin
        w_stage_nxt = {r_stage[DW-WIDTH-1:0], si_l};
        w_so_l_nxt  = r_stage[DW-1 -: WIDTH];
      end else begin
        w_stage_nxt = {(w_rot ? r_stage[WIDTH-1:0] : si_r), r_stage[DW-1:WIDTH]};
        w_so_r_nxt  = r_stage[WIDTH-1:0];
      end
      if (r_state == S_ACTIVE) begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end else if (r_cnt != CW'(N)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_so_r  <= '0;
      r_so_l  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_so_r  <= w_so_r_nxt;
      r_so_l  <= w_so_l_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign dout = r_stage;
  assign so_r = r_so_r;
  assign so_l = r_so_l;
  assign cnt  = r_cnt;
  assign busy = (r_state == S_ACTIVE);
  assign done = r_done;

endmodule
